// File: rtl/sseg_scan_driver_pkg.sv
// Shared constants and types for the multiplexed seven-segment scan driver.
//   SsegBlank   : all segments off (patterns are active-low, bit7 = DP)
//   AnodeOff    : all six digit enables off (active-low)
//   NumDigits   : digits on the shared segment bus
//   PwmW        : brightness / PWM counter width
//   scan_state_e: per-slot phase, dark gap first, then drive
package sseg_scan_driver_pkg;

  localparam logic [7:0]  SsegBlank = 8'hFF;
  localparam logic [5:0]  AnodeOff  = 6'h3F;
  localparam int unsigned NumDigits = 6;
  localparam int unsigned PwmW      = 4;

  typedef enum logic {
    ScanBlank = 1'b0,
    ScanDrive = 1'b1
  } scan_state_e;

  // Active-low one-cold digit enable for digit idx.
  function automatic logic [5:0] anode_sel(input logic [2:0] idx);
    logic [5:0] one;
    one = 6'd1;
    return ~(one << idx);
  endfunction

endpackage

// File: rtl/sseg_scan_driver_timebase.sv
// Slot / digit timebase for the scan driver.
//   clk_i          : system clock
//   rst_i          : asynchronous active-high reset
//   slot_cnt_o     : current cycle within the digit slot, 0..DigitCycles-1
//   digit_idx_d_o  : digit index that will be current after the next edge
//   slot_end_o     : last cycle of a slot
//   frame_end_o    : last cycle of the slot of digit 5 (digit index wraps next edge)
module sseg_scan_driver_timebase
  import sseg_scan_driver_pkg::*;
#(
  parameter int unsigned DigitCycles = 50000
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  output logic [$clog2(DigitCycles)-1:0]   slot_cnt_o,
  output logic [2:0]                       digit_idx_d_o,
  output logic                             slot_end_o,
  output logic                             frame_end_o
);

  localparam int unsigned SlotW = $clog2(DigitCycles);
  localparam logic [SlotW-1:0] SlotLast  = SlotW'(DigitCycles - 1);
  localparam logic [2:0]       DigitLast = 3'(NumDigits - 1);

  logic [SlotW-1:0] slot_q, slot_d;
  logic [2:0]       digit_q, digit_d;
  logic             slot_end, frame_end;

  always_comb begin
    slot_end  = (slot_q == SlotLast);
    frame_end = slot_end && (digit_q == DigitLast);
    slot_d    = slot_end ? '0 : slot_q + 1'b1;
    digit_d   = digit_q;
    if (slot_end) begin
      digit_d = (digit_q == DigitLast) ? 3'd0 : digit_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q  <= '0;
      digit_q <= 3'd0;
    end else begin
      slot_q  <= slot_d;
      digit_q <= digit_d;
    end
  end

  assign slot_cnt_o    = slot_q;
  assign digit_idx_d_o = digit_d;
  assign slot_end_o    = slot_end;
  assign frame_end_o   = frame_end;

endmodule

// File: rtl/sseg_scan_driver.sv
// Six-digit seven-segment scan driver with anti-ghost blanking, per-frame snapshots and
// 16-level PWM brightness.
//   clk          : system clock
//   reset        : asynchronous active-high reset
//   sseg5..sseg0 : segment patterns, active-low, bit7 = DP; sseg0 = rightmost digit
//   brightness   : 0 = 1/16 duty .. 15 = full duty (taken once per frame)
//   enable       : 0 keeps every digit dark; timing keeps running
//   seg_out      : shared segment bus, active-low
//   an_out       : digit enables, active-low, at most one low
//   frame_tick   : one-cycle pulse after each new frame snapshot
module sseg_scan_driver
  import sseg_scan_driver_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      sseg5,
  input  logic [7:0]      sseg4,
  input  logic [7:0]      sseg3,
  input  logic [7:0]      sseg2,
  input  logic [7:0]      sseg1,
  input  logic [7:0]      sseg0,
  input  logic [PwmW-1:0] brightness,
  input  logic            enable,
  output logic [7:0]      seg_out,
  output logic [5:0]      an_out,
  output logic            frame_tick
);

  localparam int unsigned SlotW = $clog2(DIGIT_CYCLES);
  localparam logic [SlotW-1:0] BlankLast = SlotW'(BLANK_CYCLES - 1);

  logic [SlotW-1:0] slot_cnt;
  logic [2:0]       digit_idx_d;
  logic             slot_end, frame_end;

  sseg_scan_driver_timebase #(
    .DigitCycles (DIGIT_CYCLES)
  ) u_timebase (
    .clk_i         (clk),
    .rst_i         (reset),
    .slot_cnt_o    (slot_cnt),
    .digit_idx_d_o (digit_idx_d),
    .slot_end_o    (slot_end),
    .frame_end_o   (frame_end)
  );

  scan_state_e     state_q, state_d;
  logic [7:0]      sseg_in [NumDigits];
  logic [7:0]      snap_q  [NumDigits];
  logic [7:0]      snap_d  [NumDigits];
  logic [PwmW-1:0] bright_q, bright_d;
  logic [PwmW-1:0] pwm_q, pwm_d;
  logic            lit;
  logic [7:0]      seg_d;
  logic [5:0]      an_d;

  always_comb begin
    sseg_in[0] = sseg0;
    sseg_in[1] = sseg1;
    sseg_in[2] = sseg2;
    sseg_in[3] = sseg3;
    sseg_in[4] = sseg4;
    sseg_in[5] = sseg5;
  end

  // Outputs are computed from next-state values so the pins change on the very edge that
  // updates the FSM and counters.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ScanBlank: if (slot_cnt == BlankLast) state_d = ScanDrive;
      ScanDrive: if (slot_end)              state_d = ScanBlank;
    endcase

    snap_d   = snap_q;
    bright_d = bright_q;
    if (frame_end) begin
      snap_d   = sseg_in;
      bright_d = brightness;
    end

    pwm_d = pwm_q + 1'b1;
    lit   = enable && (state_d == ScanDrive) && (pwm_d <= bright_d);

    an_d  = AnodeOff;
    seg_d = SsegBlank;
    if (lit) begin
      an_d  = anode_sel(digit_idx_d);
      seg_d = snap_d[digit_idx_d];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ScanBlank;
      snap_q     <= '{default: SsegBlank};
      bright_q   <= '0;
      pwm_q      <= '0;
      seg_out    <= SsegBlank;
      an_out     <= AnodeOff;
      frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      bright_q   <= bright_d;
      pwm_q      <= pwm_d;
      seg_out    <= seg_d;
      an_out     <= an_d;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver with DIGIT_CYCLES=8, BLANK_CYCLES=2.
// A cycle-indexed reference (cycle n since reset release: slot n%8, digit (n/8)%6,
// PWM n%16, snapshot every 48 cycles) is compared every cycle, alongside hand-picked
// constant expectations and a continuous anti-ghost monitor.
module tb_sseg_scan_driver;

  logic       clk;
  logic       reset;
  logic [7:0] sseg [6];
  logic [3:0] brightness;
  logic       enable;
  logic [7:0] seg_out;
  logic [5:0] an_out;
  logic       frame_tick;

  int n_total = 0;
  int n_bad   = 0;

  sseg_scan_driver #(
    .DIGIT_CYCLES (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sseg5      (sseg[5]),
    .sseg4      (sseg[4]),
    .sseg3      (sseg[3]),
    .sseg2      (sseg[2]),
    .sseg1      (sseg[1]),
    .sseg0      (sseg[0]),
    .brightness (brightness),
    .enable     (enable),
    .seg_out    (seg_out),
    .an_out     (an_out),
    .frame_tick (frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference state
  int         m_n;
  logic [7:0] m_snap [6];
  logic [3:0] m_bright;

  task automatic model_reset();
    m_n      = 0;
    m_snap   = '{default: 8'hFF};
    m_bright = 4'd0;
  endtask

  // One clock: capture inputs the DUT samples, advance, then compare at posedge+1.
  task automatic step();
    logic [7:0] cap [6];
    logic [3:0] br;
    logic       en;
    logic [5:0] one;
    logic [5:0] exp_an;
    logic [7:0] exp_seg;
    int         slot, digit;
    bit         lit;
    cap = sseg;
    br  = brightness;
    en  = enable;
    @(posedge clk);
    #1;
    m_n++;
    if (m_n % 48 == 0) begin
      m_snap   = cap;
      m_bright = br;
    end
    slot  = m_n % 8;
    digit = (m_n / 8) % 6;
    lit   = en && (slot >= 2) && ((m_n % 16) <= int'(m_bright));
    one   = 6'd1;
    exp_an  = lit ? ~(one << digit) : 6'h3F;
    exp_seg = lit ? m_snap[digit] : 8'hFF;
    check("an_out", 32'(an_out), 32'(exp_an));
    check("seg_out", 32'(seg_out), 32'(exp_seg));
    check("frame_tick", 32'(frame_tick), (m_n % 48 == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic run_to(input int target);
    while (m_n < target) step();
  endtask

  task automatic expect_pins(input string tag, input logic [5:0] an, input logic [7:0] seg);
    check({tag, "_an"}, 32'(an_out), 32'(an));
    check({tag, "_seg"}, 32'(seg_out), 32'(seg));
  endtask

  // Anti-ghost monitor: one-cold enables, >= 2 dark cycles between different digits.
  bit ghost_on = 1'b0;
  bit have_last;
  int last_digit;
  int dark_run;
  always @(negedge clk) begin
    if (reset || !ghost_on) begin
      have_last = 1'b0;
      dark_run  = 0;
    end else begin
      check("onecold", 32'($countones(~an_out) <= 1), 32'd1);
      if ($countones(~an_out) == 1) begin
        for (int i = 0; i < 6; i++) begin
          if (!an_out[i]) begin
            if (have_last && (i != last_digit)) check("gap", 32'(dark_run >= 2), 32'd1);
            last_digit = i;
          end
        end
        have_last = 1'b1;
        dark_run  = 0;
      end else begin
        dark_run++;
      end
    end
  end

  initial begin
    sseg[0] = 8'hC0; sseg[1] = 8'hF9; sseg[2] = 8'hA4;
    sseg[3] = 8'hB0; sseg[4] = 8'h99; sseg[5] = 8'h92;
    brightness = 4'd15;
    enable     = 1'b1;
    reset      = 1'b0;
    #1 reset = 1'b1;
    #2;
    expect_pins("reset", 6'h3F, 8'hFF);
    check("reset_tick", 32'(frame_tick), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    ghost_on = 1'b1;

    // Scan order; first frame is dark (reset snapshot blank, brightness 0).
    run_to(2);   expect_pins("first_frame", 6'h3F, 8'hFF);
    run_to(48);  check("tick1", 32'(frame_tick), 32'd1);
    run_to(50);  expect_pins("d0", 6'h3E, 8'hC0);
    run_to(58);  expect_pins("d1", 6'h3D, 8'hF9);
    run_to(66);  expect_pins("d2", 6'h3B, 8'hA4);
    run_to(74);  expect_pins("d3", 6'h37, 8'hB0);
    run_to(82);  expect_pins("d4", 6'h2F, 8'h99);
    run_to(90);  expect_pins("d5", 6'h1F, 8'h92);
    run_to(96);  expect_pins("d0_blank", 6'h3F, 8'hFF);

    // Tearing: change mid-frame, shown only after the next snapshot.
    run_to(116); sseg[3] = 8'h80;
    run_to(122); expect_pins("tear_old", 6'h37, 8'hB0);
    run_to(144); check("tick3", 32'(frame_tick), 32'd1);
    run_to(170); expect_pins("tear_new", 6'h37, 8'h80);

    // Brightness 0 then 7.
    brightness = 4'd0;
    run_to(194); expect_pins("br0_d0", 6'h3F, 8'hFF);
    brightness = 4'd7;
    run_to(242); expect_pins("br7_d0", 6'h3E, 8'hC0);
    run_to(250); expect_pins("br7_d1", 6'h3F, 8'hFF);
    run_to(258); expect_pins("br7_d2", 6'h3B, 8'hA4);
    brightness = 4'd15;

    // Enable off mid-DRIVE of digit 1, back on during digit 1 of the next frame.
    run_to(300); expect_pins("en_before", 6'h3D, 8'hF9);
    enable = 1'b0;
    run_to(301); expect_pins("en_off", 6'h3F, 8'hFF);
    run_to(336); check("tick_en_off", 32'(frame_tick), 32'd1);
    run_to(350); enable = 1'b1;
    run_to(351); expect_pins("en_back", 6'h3D, 8'hF9);

    // Asynchronous reset during digit 4 DRIVE.
    run_to(420); expect_pins("pre_reset", 6'h2F, 8'h99);
    #2 reset = 1'b1;
    #1;
    expect_pins("async_reset", 6'h3F, 8'hFF);
    check("async_reset_tick", 32'(frame_tick), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    run_to(2);   expect_pins("post_reset_c2", 6'h3F, 8'hFF);
    run_to(47);  check("no_early_tick", 32'(frame_tick), 32'd0);
    run_to(48);  check("post_reset_tick", 32'(frame_tick), 32'd1);
    run_to(50);  expect_pins("post_reset_d0", 6'h3E, 8'hC0);
    run_to(100);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
